// File: rtl/alu_pkg.sv
// Shared opcode constants and sequencer state encoding for the ALU op sequencer.
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;
  localparam logic [4:0] OP_SLL = 5'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_WAIT_SH = 2'd2,
    ST_RESP    = 2'd3
  } seq_state_t;

  function automatic logic is_legal_op(input logic [4:0] op);
    return op <= OP_SLL;
  endfunction

endpackage

// File: rtl/alu_simple_unit.sv
// Combinational ADD/SUB/AND/OR/XOR datapath; SLL is executed by the external shifter.
module alu_simple_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       ctrl,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  always_comb begin
    result  = '0;
    illegal = !is_legal_op(ctrl);
    case (ctrl)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Request/response ALU sequencer with an external shift unit for SLL.
// Optional shifter wait timeout enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       ctrl,
  output logic             sh_start,
  output logic [WIDTH-1:0] sh_a,
  output logic [4:0]       sh_b,
  input  logic             sh_done,
  input  logic [WIDTH-1:0] sh_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err
);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [WIDTH-1:0] b_q;
  logic [4:0]       ctrl_q;
  logic [WIDTH-1:0] alu_result;
  logic             alu_illegal;
  logic             is_sll;
  logic             accept;
  logic             timeout_hit;

  // sh_a doubles as the registered A operand for the simple ALU ops.
  alu_simple_unit #(.WIDTH(WIDTH)) u_simple (
    .a       (sh_a),
    .b       (b_q),
    .ctrl    (ctrl_q),
    .result  (alu_result),
    .illegal (alu_illegal)
  );

  assign is_sll = (ctrl_q == OP_SLL);
  assign accept = in_valid && in_ready;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state != ST_WAIT_SH) begin
      wait_cnt <= '0;
    end else if (!sh_done) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Fires on the last of TIMEOUT consecutive WAIT_SH cycles without sh_done.
  assign timeout_hit = (state == ST_WAIT_SH) && !sh_done &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    sh_start  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = !rst;
        if (in_valid) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        sh_start  = is_sll;
        state_nxt = is_sll ? ST_WAIT_SH : ST_RESP;
      end
      ST_WAIT_SH: begin
        if (sh_done || timeout_hit) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_q        <= '0;
      ctrl_q     <= '0;
      sh_a       <= '0;
      sh_b       <= '0;
      out_result <= '0;
      out_err    <= 1'b0;
    end else begin
      if (accept) begin
        sh_a   <= a;
        sh_b   <= b[4:0];
        b_q    <= b;
        ctrl_q <= ctrl;
      end
      case (state)
        ST_EXEC: begin
          if (!is_sll) begin
            out_result <= alu_illegal ? '0 : alu_result;
            out_err    <= alu_illegal;
          end
        end
        ST_WAIT_SH: begin
          if (sh_done) begin
            out_result <= sh_result;
            out_err    <= 1'b0;
          end else if (timeout_hit) begin
            out_result <= '0;
            out_err    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural shift-unit model.
module tb_alu_op_sequencer;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [4:0]       ctrl = '0;
  logic             sh_start;
  logic [WIDTH-1:0] sh_a;
  logic [4:0]       sh_b;
  logic             sh_done;
  logic [WIDTH-1:0] sh_result;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_result;
  logic             out_err;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .ctrl       (ctrl),
    .sh_start   (sh_start),
    .sh_a       (sh_a),
    .sh_b       (sh_b),
    .sh_done    (sh_done),
    .sh_result  (sh_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // External shift unit model plus accept/response monitors.
  logic             model_en    = 1'b1;
  int               sh_delay    = 5;
  logic             model_done  = 1'b0;
  logic             manual_done = 1'b0;
  int               sh_cd       = 0;
  logic             sh_busy     = 1'b0;
  logic [WIDTH-1:0] sh_res_m    = '0;
  int               sh_pulses   = 0;
  logic             start_seen;
  int               acc_q[$];
  logic [WIDTH-1:0] res_q[$];
  logic             err_q[$];

  assign sh_done   = model_done | manual_done;
  assign sh_result = sh_res_m;

  always @(posedge clk) begin
    cyc++;
    start_seen = sh_start;
    if (!rst && in_valid && in_ready) acc_q.push_back(cyc);
    if (!rst && out_valid && out_ready) begin
      res_q.push_back(out_result);
      err_q.push_back(out_err);
    end
    if (start_seen) sh_pulses++;
    #1;
    model_done = 1'b0;
    if (rst) begin
      sh_busy = 1'b0;
    end else if (start_seen && model_en) begin
      sh_busy  = 1'b1;
      sh_cd    = sh_delay;
      sh_res_m = sh_a << sh_b;
    end else if (sh_busy) begin
      sh_cd--;
      if (sh_cd == 0) begin
        model_done = 1'b1;
        sh_busy    = 1'b0;
      end
    end
  end

  function automatic void ref_op(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                 input logic [4:0] rc,
                                 output logic [WIDTH-1:0] res, output logic err);
    logic [4:0] amt;
    amt = rb[4:0];
    err = 1'b0;
    case (rc)
      5'd0: res = ra + rb;
      5'd1: res = ra - rb;
      5'd2: res = ra & rb;
      5'd3: res = ra | rb;
      5'd4: res = ra ^ rb;
      5'd5: res = ra << amt;
      default: begin res = '0; err = 1'b1; end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                       input logic [4:0] tc, output bit ok);
    a = ta; b = tb_; ctrl = tc; in_valid = 1'b1; ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output bit seen);
    seen = out_valid;
    for (int n = 0; n < limit && !seen; n++) begin
      tick();
      seen = out_valid;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick(); tick();
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    tests++;
    if ({out_valid, sh_start, out_err} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: got valid/start/err %b%b%b expected 000", out_valid, sh_start, out_err);
    end
    tests++;
    if (out_result !== '0 || sh_a !== '0 || sh_b !== '0) begin
      fails++; $display("FAIL reset_data: got result %h sh_a %h sh_b %h expected zeros", out_result, sh_a, sh_b);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_add_wrap();
    bit ok;
    out_ready = 1'b1;
    issue(32'hFFFF_FFFF, 32'h1, 5'd0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL add_accept: got no accept expected accept"); end
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL add_exec_valid: got %b expected 0", out_valid); end
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_result !== 32'h0 || out_err !== 1'b0) begin
      fails++; $display("FAIL add_wrap: got valid %b result %h err %b expected 1 00000000 0", out_valid, out_result, out_err);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL add_release: got valid %b in_ready %b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_sll();
    bit ok, seen;
    int p0, acc;
    model_en = 1'b1; sh_delay = 5; out_ready = 1'b1;
    p0 = sh_pulses;
    issue(32'h3, 32'h4, 5'd5, ok);
    acc = cyc;
    tests++;
    if (!ok || sh_start !== 1'b1 || sh_a !== 32'h3 || sh_b !== 5'd4) begin
      fails++; $display("FAIL sll_launch: got ok %b start %b sh_a %h sh_b %0d expected 1 1 3 4", ok, sh_start, sh_a, sh_b);
    end
    wait_valid(50, seen);
    tests++;
    if (!seen || cyc - acc != 7) begin
      fails++; $display("FAIL sll_latency: got seen %b after %0d cycles expected 1 after 7", seen, cyc - acc);
    end
    tests++;
    if (out_result !== 32'h30 || out_err !== 1'b0 || sh_b !== 5'd4) begin
      fails++; $display("FAIL sll_result: got %h err %b sh_b %0d expected 00000030 0 4", out_result, out_err, sh_b);
    end
    tests++;
    if (sh_pulses - p0 != 1) begin fails++; $display("FAIL sll_pulses: got %0d expected 1", sh_pulses - p0); end
    tick();
  endtask

  task automatic test_illegal_stall();
    bit ok, seen;
    out_ready = 1'b0;
    issue($urandom, $urandom, 5'd9, ok);
    wait_valid(10, seen);
    tests++;
    if (!ok || !seen || out_result !== '0 || out_err !== 1'b1 || in_ready !== 1'b0) begin
      fails++; $display("FAIL illegal_resp: got valid %b result %h err %b in_ready %b expected 1 0 1 0", seen, out_result, out_err, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if ({out_valid, out_err, in_ready} !== 3'b110 || out_result !== '0) begin
        fails++; $display("FAIL illegal_hold: got valid/err/ready %b%b%b result %h expected 110 0", out_valid, out_err, in_ready, out_result);
      end
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL illegal_release: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_in_wait();
    bit ok, bad;
    int n0;
    model_en = 1'b0; out_ready = 1'b1;
    n0 = res_q.size();
    issue(32'h7, 32'h2, 5'd5, ok);
    tick(); tick();
    rst = 1'b1;
    tick();
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || sh_a !== '0) begin
      fails++; $display("FAIL rstwait_during: got in_ready %b valid %b sh_a %h expected 0 0 0", in_ready, out_valid, sh_a);
    end
    tick();
    rst = 1'b0; manual_done = 1'b1;
    tick();
    manual_done = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) bad = 1'b1;
      tick();
    end
    tests++;
    if (bad || res_q.size() != n0) begin fails++; $display("FAIL rstwait_late_done: got stray valid %b expected 0", bad); end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL rstwait_ready: got %b expected 1", in_ready); end
    model_en = 1'b1;
  endtask

  task automatic test_timeout();
    bit ok;
    int acc;
    model_en = 1'b0; out_ready = 1'b1;
    issue(32'h1, 32'h1, 5'd5, ok);
    acc = cyc;
`ifdef ALU_SEQ_TIMEOUT_EN
    begin
      bit seen;
      wait_valid(50, seen);
      tests++;
      if (!seen || cyc - acc != int'(TIMEOUT) + 1 || out_err !== 1'b1 || out_result !== '0) begin
        fails++; $display("FAIL timeout_resp: got seen %b at %0d err %b result %h expected 1 at %0d 1 0", seen, cyc - acc, out_err, out_result, TIMEOUT + 1);
      end
      tick();
    end
`else
    begin
      bit stuck;
      stuck = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (out_valid) stuck = 1'b1;
        tick();
      end
      tests++;
      if (!ok || stuck) begin fails++; $display("FAIL no_timeout: got valid %b within 100 cycles expected 0 (accepted %b)", stuck, ok); end
      rst = 1'b1; tick(); rst = 1'b0; tick();
    end
`endif
    model_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, seen;
    int n0, a0;
    model_en = 1'b1; out_ready = 1'b1;
    n0 = res_q.size(); a0 = acc_q.size();
    issue(32'd5, 32'd7, 5'd1, ok1);
    issue(32'h0000_F0F0, 32'h0000_0FF0, 5'd4, ok2);
    wait_valid(20, seen);
    tick();
    tests++;
    if (!ok1 || !ok2 || res_q.size() != n0 + 2 || acc_q.size() != a0 + 2) begin
      fails++; $display("FAIL b2b_count: got %0d responses expected 2", res_q.size() - n0);
    end else begin
      tests++;
      if (res_q[n0] !== 32'hFFFF_FFFE || err_q[n0] !== 1'b0) begin
        fails++; $display("FAIL b2b_sub: got %h err %b expected fffffffe 0", res_q[n0], err_q[n0]);
      end
      tests++;
      if (res_q[n0+1] !== 32'h0000_FF00 || err_q[n0+1] !== 1'b0) begin
        fails++; $display("FAIL b2b_xor: got %h err %b expected 0000ff00 0", res_q[n0+1], err_q[n0+1]);
      end
      tests++;
      if (acc_q[a0+1] - acc_q[a0] < 3) begin
        fails++; $display("FAIL b2b_spacing: got %0d cycles expected >= 3", acc_q[a0+1] - acc_q[a0]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int n0;
    logic [WIDTH-1:0] ra, rb, exp_r;
    logic [4:0] rc;
    logic exp_e;
    model_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom;
      rc = ($urandom_range(0, 7) < 6) ? 5'($urandom_range(0, 5)) : 5'($urandom_range(6, 31));
      sh_delay = $urandom_range(1, 6);
      ref_op(ra, rb, rc, exp_r, exp_e);
      out_ready = 1'b0;
      n0 = res_q.size();
      issue(ra, rb, rc, ok);
      for (int n = 0; n < 100 && res_q.size() == n0; n++) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
      out_ready = 1'b0;
      tests++;
      if (!ok || res_q.size() != n0 + 1) begin
        fails++; $display("FAIL rand_resp_count op %0d ctrl %0d: got %0d responses expected 1", i, rc, res_q.size() - n0);
      end else if (res_q[n0] !== exp_r || err_q[n0] !== exp_e) begin
        fails++; $display("FAIL rand_result op %0d ctrl %0d: got %h err %b expected %h err %b", i, rc, res_q[n0], err_q[n0], exp_r, exp_e);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_wrap();
    test_sll();
    test_illegal_stall();
    test_reset_in_wait();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
